// File: rtl/scan_scheduler_if.sv
// Control/status bundle for scan_scheduler: enable, period-load handshake and scan outputs.
interface scan_scheduler_if #(
    parameter int N_DIGITS = 4,
    parameter int DIV_W    = 20
);
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                en;
    logic [DIV_W-1:0]    div_value;
    logic                div_load;
    logic                div_busy;
    logic                tick;
    logic [SEL_W-1:0]    digit_sel;
    logic [N_DIGITS-1:0] digit_en;
    logic                frame_done;

    modport master (
        output en, div_value, div_load,
        input  div_busy, tick, digit_sel, digit_en, frame_done
    );

    modport slave (
        input  en, div_value, div_load,
        output div_busy, tick, digit_sel, digit_en, frame_done
    );
endinterface

// File: rtl/scan_scheduler.sv
// Synchronous prescaler and one-hot digit scan sequencer with run-time period reload.
// Define SCAN_BLANK_EN to blank the digits for BLANK_CYC cycles at the start of every period.
module scan_scheduler #(
    parameter int N_DIGITS    = 4,
    parameter int DIV_W       = 20,
    parameter int DIV_DEFAULT = 262144,
    parameter int BLANK_CYC   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    scan_scheduler_if.slave bus
);
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

`ifdef SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
    localparam bit BLANK_EN = 1'b0;
    typedef enum logic {IDLE, SHOW} state_t;
`endif

    localparam int                BLANK_LEN = BLANK_EN ? BLANK_CYC : 0;
    localparam logic [DIV_W-1:0]  MIN_P     = DIV_W'(BLANK_LEN + 2);
    localparam logic [DIV_W-1:0]  DEF_P     = DIV_W'(DIV_DEFAULT);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);
`ifdef SCAN_BLANK_EN
    localparam logic [DIV_W-1:0]  BLANK_LAST = DIV_W'(BLANK_LEN - 1);
`endif

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [DIV_W-1:0] pending_q, pending_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             active;
    logic             tick;

    assign active = (state_q != IDLE);
    assign tick   = active && (cnt_q == period_q - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
`ifdef SCAN_BLANK_EN
                    state_d = BLANK;
`else
                    state_d = SHOW;
`endif
                end
            end
            SHOW: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (tick) begin
`ifdef SCAN_BLANK_EN
                    state_d = BLANK;
`else
                    state_d = SHOW;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = BLANK;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // A pending period is applied on a tick or on leaving IDLE; a load in that same
    // cycle is captured afterwards, so it waits for the following boundary.
    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        sel_d     = sel_q;
        if (!active) begin
            cnt_d = '0;
            sel_d = '0;
            if (bus.en && busy_q) begin
                period_d = pending_q;
                busy_d   = 1'b0;
            end
        end else if (!bus.en) begin
            cnt_d = '0;
            sel_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
            if (busy_q) begin
                period_d = pending_q;
                busy_d   = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (bus.div_load) begin
            pending_d = (bus.div_value < MIN_P) ? MIN_P : bus.div_value;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            period_q  <= DEF_P;
            pending_q <= '0;
            busy_q    <= 1'b0;
            sel_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            sel_q     <= sel_d;
        end
    end

    always_comb begin
        bus.tick       = tick;
        bus.frame_done = tick && (sel_q == LAST_SEL);
        bus.digit_sel  = sel_q;
        bus.div_busy   = busy_q;
        bus.digit_en   = '0;
        if (state_q == SHOW) begin
            bus.digit_en = ONE_HOT0 << sel_q;
        end
    end
endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler: tick spacing, digit sequence, period reloads, en drop and reset.
// Tick gaps are queued as expectations when stimulus is driven and popped as ticks are observed.
module tb_scan_scheduler;
    localparam int N_DIGITS  = 4;
    localparam int DIV_W     = 20;
    localparam int BLANK_CYC = 16;
    localparam int BUDGET    = 200;
`ifdef SCAN_BLANK_EN
    localparam int P0        = 20;
    localparam int BLANK_EXP = BLANK_CYC;
    localparam int V_SAME    = 25;
    localparam int W_DROP    = 22;
    localparam int X_RESET   = 30;
`else
    localparam int P0        = 8;
    localparam int BLANK_EXP = 0;
    localparam int V_SAME    = 5;
    localparam int W_DROP    = 6;
    localparam int X_RESET   = 9;
`endif

    typedef struct {
        logic [DIV_W-1:0] value;
        int               expPeriod;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   lastTick = 0;
    int   expSel   = 0;
    int   curP     = P0;
    int   gapQ[$];
    vec_t vecs[5];

    scan_scheduler_if #(.N_DIGITS(N_DIGITS), .DIV_W(DIV_W)) bus ();

    scan_scheduler #(
        .N_DIGITS(N_DIGITS),
        .DIV_W(DIV_W),
        .DIV_DEFAULT(P0),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic l, input logic [DIV_W-1:0] v);
        bus.en        = e;
        bus.div_load  = l;
        bus.div_value = v;
    endtask

    // Loads are single-cycle: the pulse is dropped right after the edge that samples it.
    task automatic step();
        @(posedge clk);
        #1;
        bus.div_load = 1'b0;
        cyc++;
    endtask

    task automatic waitTick(output int gap);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tick !== 1'b1 && n < BUDGET);
        if (bus.tick !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL tick_timeout: got no tick, expected one within %0d cycles", BUDGET);
            gap = -1;
        end else begin
            gap = cyc - lastTick;
            checkOutput("digit_en_at_tick", bus.digit_en, 32'(1) << expSel);
            checkOutput("frame_done_at_tick", bus.frame_done, 32'(expSel == N_DIGITS - 1));
            expSel = (expSel + 1) % N_DIGITS;
        end
        lastTick = cyc;
    endtask

    task automatic popGap(input string name, input int gap);
        if (gapQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got gap %0d, expected nothing queued", name, gap);
        end else begin
            checkOutput(name, gap, gapQ.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int zeros;
        int n;

`ifdef SCAN_BLANK_EN
        vecs[0] = '{value: 20'd0,  expPeriod: 18};
        vecs[1] = '{value: 20'd1,  expPeriod: 18};
        vecs[2] = '{value: 20'd5,  expPeriod: 18};
        vecs[3] = '{value: 20'd25, expPeriod: 25};
        vecs[4] = '{value: 20'd20, expPeriod: 20};
`else
        vecs[0] = '{value: 20'd5, expPeriod: 5};
        vecs[1] = '{value: 20'd0, expPeriod: 2};
        vecs[2] = '{value: 20'd1, expPeriod: 2};
        vecs[3] = '{value: 20'd3, expPeriod: 3};
        vecs[4] = '{value: 20'd8, expPeriod: 8};
`endif

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tick", bus.tick, 0);
        checkOutput("reset_digit_en", bus.digit_en, 0);
        checkOutput("reset_digit_sel", bus.digit_sel, 0);
        checkOutput("reset_frame_done", bus.frame_done, 0);
        checkOutput("reset_div_busy", bus.div_busy, 0);
        rst_n = 1'b1;
        step();
        step();

        // Enable with the default period: four digits in order, frame_done on the last.
        applyStimulus(1'b1, 1'b0, '0);
        lastTick = cyc;
        expSel   = 0;
        step();
        checkOutput("digit_en_first_cycle", bus.digit_en, (BLANK_EXP > 0) ? 0 : 1);
        for (int i = 0; i < 5; i++) begin
            gapQ.push_back(P0);
            waitTick(g);
            popGap("gap_default", g);
        end

        zeros = 0;
        for (int i = 0; i < P0; i++) begin
            step();
            if (bus.digit_en == '0) zeros++;
        end
        checkOutput("blank_cycles", zeros, BLANK_EXP);
        checkOutput("tick_after_count", bus.tick, 1);
        lastTick = cyc;
        expSel   = (expSel + 1) % N_DIGITS;

        // Mid-period loads, including clamped values.
        for (int v = 0; v < 5; v++) begin
            step();
            applyStimulus(1'b1, 1'b1, vecs[v].value);
            gapQ.push_back(curP);
            gapQ.push_back(vecs[v].expPeriod);
            gapQ.push_back(vecs[v].expPeriod);
            waitTick(g);
            popGap("gap_old_period", g);
            checkOutput("busy_before_apply", bus.div_busy, 1);
            waitTick(g);
            popGap("gap_new_period", g);
            checkOutput("busy_after_apply", bus.div_busy, 0);
            waitTick(g);
            popGap("gap_new_period_2", g);
            curP = vecs[v].expPeriod;
        end

        // Load in the tick cycle itself: old period runs once more.
        applyStimulus(1'b1, 1'b1, DIV_W'(V_SAME));
        gapQ.push_back(curP);
        gapQ.push_back(V_SAME);
        gapQ.push_back(V_SAME);
        waitTick(g);
        popGap("gap_same_cycle_load", g);
        checkOutput("busy_same_cycle_load", bus.div_busy, 1);
        waitTick(g);
        popGap("gap_after_same_cycle", g);
        checkOutput("busy_cleared_same_cycle", bus.div_busy, 0);
        waitTick(g);
        popGap("gap_after_same_cycle_2", g);
        curP = V_SAME;

        // Drop en while digit 2 is shown with a load pending.
        n = 0;
        while (expSel != 2 && n < 8) begin
            waitTick(g);
            n++;
        end
        step();
        repeat (BLANK_EXP) step();
        checkOutput("digit_sel_before_drop", bus.digit_sel, 2);
        checkOutput("digit_en_before_drop", bus.digit_en, 4);
        applyStimulus(1'b1, 1'b1, DIV_W'(W_DROP));
        step();
        applyStimulus(1'b0, 1'b0, DIV_W'(W_DROP));
        step();
        checkOutput("idle_digit_en", bus.digit_en, 0);
        checkOutput("idle_digit_sel", bus.digit_sel, 0);
        checkOutput("idle_tick", bus.tick, 0);
        checkOutput("idle_frame_done", bus.frame_done, 0);
        checkOutput("idle_busy_kept", bus.div_busy, 1);
        repeat (3) step();
        checkOutput("idle_busy_held", bus.div_busy, 1);
        checkOutput("idle_digit_en_held", bus.digit_en, 0);
        applyStimulus(1'b1, 1'b0, '0);
        lastTick = cyc;
        expSel   = 0;
        gapQ.push_back(W_DROP);
        waitTick(g);
        popGap("gap_after_reenable", g);
        checkOutput("busy_after_reenable", bus.div_busy, 0);
        gapQ.push_back(W_DROP);
        waitTick(g);
        popGap("gap_after_reenable_2", g);

        // Asynchronous reset with a load pending.
        step();
        applyStimulus(1'b1, 1'b1, DIV_W'(X_RESET));
        step();
        checkOutput("busy_before_reset", bus.div_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tick", bus.tick, 0);
        checkOutput("async_reset_digit_en", bus.digit_en, 0);
        checkOutput("async_reset_digit_sel", bus.digit_sel, 0);
        checkOutput("async_reset_frame_done", bus.frame_done, 0);
        checkOutput("async_reset_busy", bus.div_busy, 0);
        applyStimulus(1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b1;
        step();
        applyStimulus(1'b1, 1'b0, '0);
        lastTick = cyc;
        expSel   = 0;
        gapQ.push_back(P0);
        waitTick(g);
        popGap("gap_after_reset", g);
        checkOutput("busy_after_reset", bus.div_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
